bmc_heartbeat_monitor: RTL and testbench



---
 rtl/bmc_heartbeat_monitor.sv | 181 ++++++++++++++++++
 tb/tb_bmc_heartbeat_monitor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bmc_heartbeat_monitor.sv
// bmc_heartbeat_monitor: qualifies the BMC heartbeat pin (BMC_GPIO0, ~1 Hz).
// The pin is synchronised and deglitched on the 1 ms tick. The monitor
// measures the rising-to-rising period in ms and reports the heartbeat as
// alive or lost to the BIOS failover FSM.
// Optional build macro: HB_STICKY_LOST_EN. When it is defined, ST_LOST is
// absorbing and only rst exits it.
module bmc_heartbeat_monitor #(
  parameter int DEGLITCH_MS   = 3,
  parameter int MIN_PERIOD_MS = 800,
  parameter int MAX_PERIOD_MS = 1200,
  parameter int GOOD_CNT      = 3,
  parameter int TIMEOUT_MS    = 120000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ms_tick,
  input  logic        hb_in,
  output logic        hb_alive,
  output logic        hb_lost,
  output logic        lost_pulse,
  output logic [11:0] period_ms
);

  localparam int DGW = (DEGLITCH_MS < 1) ? 1 : $clog2(DEGLITCH_MS + 1);
  localparam logic [DGW-1:0] DG_LIM  = DGW'(DEGLITCH_MS);
  localparam logic [11:0]    MIN_P   = 12'(MIN_PERIOD_MS);
  localparam logic [11:0]    MAX_P   = 12'(MAX_PERIOD_MS);
  localparam logic [11:0]    PER_SAT = 12'(MAX_PERIOD_MS + 1);
  localparam logic [16:0]    TO_LIM  = 17'(TIMEOUT_MS);
  localparam logic [3:0]     GR_GOOD = 4'(GOOD_CNT);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_ALIVE   = 2'd1,
    ST_LOST    = 2'd2
  } state_e;

  logic           sync1_q, hb_s_q;
  logic           filt_q, filt_d;
  logic [DGW-1:0] dg_cnt_q, dg_cnt_d;
  logic           rise_q, rise_d;
  logic [11:0]    per_cnt_q, per_cnt_d;
  logic           first_seen_q, first_seen_d;
  logic [11:0]    period_q, period_d;
  logic [16:0]    sil_cnt_q, sil_cnt_d;
  logic [3:0]     good_run_q, good_run_d;
  state_e         state_q, state_d;
  logic           hb_alive_q, hb_lost_q, lost_pulse_q;
  logic           scored, in_range, good, bad, timeout;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      hb_s_q  <= 1'b0;
    end else begin
      sync1_q <= hb_in;
      hb_s_q  <= sync1_q;
    end
  end

  // Deglitch: a new level must persist DEGLITCH_MS ticks before it is accepted.
  always_comb begin
    filt_d   = filt_q;
    dg_cnt_d = dg_cnt_q;
    if (hb_s_q == filt_q) begin
      dg_cnt_d = '0;
    end else if (dg_cnt_q == DG_LIM) begin
      filt_d   = ~filt_q;
      dg_cnt_d = '0;
    end else if (ms_tick) begin
      dg_cnt_d = dg_cnt_q + DGW'(1);
    end
    rise_d = filt_d & ~filt_q;
  end

  // Period measurement, scoring, and the silence counter.
  always_comb begin
    in_range     = (per_cnt_q >= MIN_P) && (per_cnt_q <= MAX_P);
    scored       = rise_q & first_seen_q;
    good         = scored & in_range;
    bad          = scored & ~in_range;
    timeout      = (sil_cnt_q == TO_LIM);
    first_seen_d = first_seen_q | rise_q;
    period_d     = scored ? per_cnt_q : period_q;
    per_cnt_d    = per_cnt_q;
    if (rise_q)
      per_cnt_d = '0;
    else if (ms_tick && (per_cnt_q < PER_SAT))
      per_cnt_d = per_cnt_q + 12'd1;
    sil_cnt_d = sil_cnt_q;
    if (good)
      sil_cnt_d = '0;
    else if (ms_tick && (sil_cnt_q < TO_LIM))
      sil_cnt_d = sil_cnt_q + 17'd1;
  end

  // Datapath registers for the filter, the edge detector and the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q       <= 1'b0;
      dg_cnt_q     <= '0;
      rise_q       <= 1'b0;
      per_cnt_q    <= '0;
      first_seen_q <= 1'b0;
      period_q     <= '0;
      sil_cnt_q    <= '0;
    end else begin
      filt_q       <= filt_d;
      dg_cnt_q     <= dg_cnt_d;
      rise_q       <= rise_d;
      per_cnt_q    <= per_cnt_d;
      first_seen_q <= first_seen_d;
      period_q     <= period_d;
      sil_cnt_q    <= sil_cnt_d;
    end
  end

  // Next-state logic. A good period always beats timeout in the same cycle.
  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    case (state_q)
      ST_ACQUIRE: begin
        if (good) begin
          good_run_d = good_run_q + 4'd1;
          if (good_run_q + 4'd1 >= GR_GOOD) state_d = ST_ALIVE;
        end else begin
          if (bad) good_run_d = '0;
          if (timeout) state_d = ST_LOST;
        end
      end
      ST_ALIVE: begin
        if (!good) begin
          if (bad) begin
            state_d    = ST_ACQUIRE;
            good_run_d = '0;
          end
          if (timeout) state_d = ST_LOST;
        end
      end
      ST_LOST: begin
`ifdef HB_STICKY_LOST_EN
        state_d = ST_LOST;
`else
        if (good) begin
          good_run_d = 4'd1;
          state_d    = (4'd1 >= GR_GOOD) ? ST_ALIVE : ST_ACQUIRE;
        end
`endif
      end
      default: begin
        state_d    = ST_ACQUIRE;
        good_run_d = '0;
      end
    endcase
  end

  // FSM state and its registered output decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ACQUIRE;
      good_run_q   <= '0;
      hb_alive_q   <= 1'b0;
      hb_lost_q    <= 1'b0;
      lost_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      good_run_q   <= good_run_d;
      hb_alive_q   <= (state_d == ST_ALIVE);
      hb_lost_q    <= (state_d == ST_LOST);
      lost_pulse_q <= (state_d == ST_LOST) && (state_q != ST_LOST);
    end
  end

  assign hb_alive   = hb_alive_q;
  assign hb_lost    = hb_lost_q;
  assign lost_pulse = lost_pulse_q;
  assign period_ms  = period_q;

endmodule

// File: tb/tb_bmc_heartbeat_monitor.sv
// Testbench for bmc_heartbeat_monitor. The bench keeps a ms-level model of
// the expected status. Period and silence are computed as "ticks since the
// last edge / good period". Health is computed from the run of consecutive
// good periods plus a lost flag. The outputs are compared to the model on
// every cycle, and directed literals are checked at key points.
module tb_bmc_heartbeat_monitor;
  localparam int DG = 2, MINP = 8, MAXP = 12, GOODN = 2, TO = 50;

  logic        clk = 1'b0;
  logic        rst, ms_tick, hb_in;
  logic        hb_alive, hb_lost, lost_pulse;
  logic [11:0] period_ms;

  bmc_heartbeat_monitor #(
    .DEGLITCH_MS(DG), .MIN_PERIOD_MS(MINP), .MAX_PERIOD_MS(MAXP),
    .GOOD_CNT(GOODN), .TIMEOUT_MS(TO)
  ) dut (
    .clk(clk), .rst(rst), .ms_tick(ms_tick), .hb_in(hb_in),
    .hb_alive(hb_alive), .hb_lost(hb_lost), .lost_pulse(lost_pulse),
    .period_ms(period_ms)
  );

  always #10 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0, pulse_cnt = 0;

  // Model state. tc counts ms ticks consumed. The marks hold tc at the last
  // edge and at the last good period.
  bit          chk_en = 1'b0;
  int          tc, rise_mark, good_mark, lag, run;
  bit          m_s1, m_s2, m_filt, m_rise, m_first, m_lost;
  logic [11:0] m_period;
  bit          e_alive, e_lost, e_pulse;

  always @(posedge clk) begin : model
    int per_pre, sil_pre;
    bit good, bad, fo, lp;
    if (rst) begin
      tc = 0; rise_mark = 0; good_mark = 0; lag = 0; run = 0;
      m_s1 = 0; m_s2 = 0; m_filt = 0; m_rise = 0; m_first = 0; m_lost = 0;
      m_period = '0; e_alive = 0; e_lost = 0; e_pulse = 0;
      chk_en = 1'b1;
    end else begin
      per_pre = tc - rise_mark;
      if (per_pre > MAXP + 1) per_pre = MAXP + 1;
      sil_pre = tc - good_mark;
      if (sil_pre > TO) sil_pre = TO;
      good = 0; bad = 0;
      if (m_rise) begin
        if (m_first) begin
          m_period = 12'(per_pre);
          if (per_pre >= MINP && per_pre <= MAXP) good = 1; else bad = 1;
        end
        m_first = 1;
      end
      lp = m_lost;
      if (good) begin
        if (run < 15) run++;
`ifndef HB_STICKY_LOST_EN
        if (m_lost) begin m_lost = 0; run = 1; end
`endif
      end else begin
        if (bad) run = 0;
        if (sil_pre == TO && !m_lost) begin m_lost = 1; run = 0; end
      end
      e_alive = !m_lost && (run >= GOODN);
      e_lost  = m_lost;
      e_pulse = m_lost && !lp;
      if (m_rise) rise_mark = tc + int'(ms_tick);
      if (good)   good_mark = tc + int'(ms_tick);
      tc = tc + int'(ms_tick);
      // A level is accepted after it has differed for DG ticks.
      fo = m_filt;
      if (m_s2 == m_filt) lag = 0;
      else if (lag == DG) begin m_filt = ~m_filt; lag = 0; end
      else if (ms_tick) lag++;
      m_rise = m_filt && !fo;
      m_s2 = m_s1;
      m_s1 = hb_in;
    end
  end

  // One clock of stimulus. It compares the DUT to the model on the falling
  // edge and then drives ms_tick for the next rising edge.
  task automatic step();
    @(negedge clk);
    if (chk_en) begin
      n_cmp++;
      if (hb_alive !== e_alive || hb_lost !== e_lost ||
          lost_pulse !== e_pulse || period_ms !== m_period) begin
        n_bad++;
        $display("FAIL model cyc=%0d alive/lost/pulse/period got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 cyc, hb_alive, hb_lost, lost_pulse, period_ms,
                 e_alive, e_lost, e_pulse, m_period);
      end
      if (lost_pulse === 1'b1) pulse_cnt++;
    end
    cyc++;
    ms_tick = (cyc % 10 == 0);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic hold(input bit lvl, input int n_ms);
    hb_in = lvl;
    repeat (n_ms * 10) step();
  endtask

  task automatic sq(input int n);
    repeat (n) begin hold(1'b0, 5); hold(1'b1, 5); end
  endtask

  task automatic pulse_rst();
    rst = 1'b1; step();
    chk("rst_alive", int'(hb_alive), 0);
    chk("rst_lost", int'(hb_lost), 0);
    chk("rst_pulse", int'(lost_pulse), 0);
    chk("rst_period", int'(period_ms), 0);
    rst = 1'b0;
  endtask

  int p0;

  initial begin
    rst = 1'b1; hb_in = 1'b0; ms_tick = 1'b0;
    repeat (4) step();
    pulse_rst();

    // Clean 10 ms wave: 1 unscored edge and then 2 good periods.
    sq(2);
    chk("acq_two_edges_alive", int'(hb_alive), 0);
    sq(1);
    chk("acq_three_edges_alive", int'(hb_alive), 1);
    chk("acq_period", int'(period_ms), 10);

    // A 1-tick glitch on the low phase is rejected.
    hold(1'b0, 2); hold(1'b1, 1); hold(1'b0, 2); hold(1'b1, 5);
    chk("glitch1_alive", int'(hb_alive), 1);
    chk("glitch1_period", int'(period_ms), 10);

    // A 2-tick pulse gets through and scores as a bad period.
    hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 3);
    chk("glitch2_alive", int'(hb_alive), 0);
    hold(1'b1, 5);
    sq(2);
    chk("realive_alive", int'(hb_alive), 1);

    // The pin is stuck high, so silence runs to the timeout.
    p0 = pulse_cnt;
    hold(1'b0, 5); hold(1'b1, 60);
    chk("stuck_lost", int'(hb_lost), 1);
    chk("stuck_alive", int'(hb_alive), 0);
    chk("stuck_pulses", pulse_cnt - p0, 1);

    // The wave resumes. The first edge sees a saturated period.
    sq(2);
`ifdef HB_STICKY_LOST_EN
    chk("resume2_lost", int'(hb_lost), 1);
    sq(2);
    chk("resume4_lost", int'(hb_lost), 1);
    chk("resume4_period", int'(period_ms), 10);
`else
    chk("resume2_lost", int'(hb_lost), 0);
    chk("resume2_alive", int'(hb_alive), 0);
    sq(2);
    chk("resume4_alive", int'(hb_alive), 1);
    chk("resume4_period", int'(period_ms), 10);
`endif

    // Reset mid-run. Reacquiring again takes 3 edges.
    pulse_rst();
    sq(2);
    chk("reacq_two_alive", int'(hb_alive), 0);
    sq(1);
    chk("reacq_three_alive", int'(hb_alive), 1);

    // A 20 ms period saturates the measurement and never counts as good.
    pulse_rst();
    repeat (5) begin hold(1'b0, 10); hold(1'b1, 10); end
    chk("slow_period", int'(period_ms), MAXP + 1);
    chk("slow_alive", int'(hb_alive), 0);
    chk("slow_lost", int'(hb_lost), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
